// File: rtl/ica_nonlin_acc.sv
// FastICA cubic-nonlinearity accumulator: a 4-stage pipeline forms g(u)=u^3 and g'(u)=3u^2,
// sums x*g, y*g, z*g and g' over a 2^N_LOG-sample frame, and presents the frame means.
module ica_nonlin_acc #(
    parameter int N_LOG = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] u,
    input  logic signed [15:0] x,
    input  logic signed [15:0] y,
    input  logic signed [15:0] z,
    output logic signed [31:0] mean_xg,
    output logic signed [31:0] mean_yg,
    output logic signed [31:0] mean_zg,
    output logic signed [31:0] mean_gp,
    output logic               out_valid,
    output logic               busy
);
    localparam int PW = 32 + N_LOG;
    localparam int GW = 20 + N_LOG;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
    state_t state_reg, state_next;

    logic [N_LOG-1:0]     cnt_reg;
    logic                 accept, clear, load_means;
    logic                 v1_reg, v2_reg, v3_reg;
    logic signed [15:0]   uq1_reg, uq2_reg, g3_reg;
    logic signed [17:0]   sq2_reg;
    logic signed [19:0]   gp3_reg, gp_next;
    logic signed [33:0]   u34, sq34, uq34, cube;
    logic signed [31:0]   uq_ext, sq_full;
    logic signed [15:0]   smp_in [3];
    logic signed [31:0]   mean_ch [3];
    logic signed [GW-1:0] accgp_reg, accgp_next;
    logic signed [31:0]   meangp_reg;

    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767)
            return 16'sh7fff;
        if (v < -34'sd32768)
            return 16'sh8000;
        return v[15:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        clear      = 1'b0;
        load_means = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ACC;
                    clear      = 1'b1;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (&cnt_reg))
                    state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // The last sample sits in S3 now; latch means from the sums including it.
                if (!v1_reg && !v2_reg) begin
                    state_next = DONE;
                    load_means = 1'b1;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    assign u34     = $signed({{2{u[31]}}, u});
    assign uq_ext  = $signed({{16{uq1_reg[15]}}, uq1_reg});
    assign sq_full = uq_ext * uq_ext;
    assign sq34    = $signed({{16{sq2_reg[17]}}, sq2_reg});
    assign uq34    = $signed({{18{uq2_reg[15]}}, uq2_reg});
    assign cube    = sq34 * uq34;
    assign gp_next = $signed({2'b00, sq2_reg}) * 20'sd3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            v1_reg  <= 1'b0;
            v2_reg  <= 1'b0;
            v3_reg  <= 1'b0;
            uq1_reg <= '0;
            uq2_reg <= '0;
            sq2_reg <= '0;
            g3_reg  <= '0;
            gp3_reg <= '0;
        end else begin
            if (clear) begin
                cnt_reg <= '0;
                v1_reg  <= 1'b0;
                v2_reg  <= 1'b0;
                v3_reg  <= 1'b0;
            end else begin
                if (accept)
                    cnt_reg <= cnt_reg + N_LOG'(1);
                v1_reg <= accept;
                v2_reg <= v1_reg;
                v3_reg <= v2_reg;
            end
            uq1_reg <= sat16(u34 >>> 14);
            uq2_reg <= uq1_reg;
            // uq^2 is never negative, so the floor shift is simply the upper slice.
            sq2_reg <= sq_full[31:14];
            g3_reg  <= sat16(cube >>> 14);
            gp3_reg <= gp_next;
        end
    end

    assign smp_in[0] = x;
    assign smp_in[1] = y;
    assign smp_in[2] = z;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic signed [15:0]   s1_reg, s2_reg, s3_reg;
            logic signed [31:0]   prod;
            logic signed [PW-1:0] acc_reg, acc_next;
            logic signed [31:0]   mean_reg;

            assign prod     = $signed({{16{s3_reg[15]}}, s3_reg}) * $signed({{16{g3_reg[15]}}, g3_reg});
            assign acc_next = v3_reg ? acc_reg + $signed({{N_LOG{prod[31]}}, prod}) : acc_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_reg   <= '0;
                    s2_reg   <= '0;
                    s3_reg   <= '0;
                    acc_reg  <= '0;
                    mean_reg <= '0;
                end else begin
                    s1_reg <= smp_in[gi];
                    s2_reg <= s1_reg;
                    s3_reg <= s2_reg;
                    if (clear)
                        acc_reg <= '0;
                    else
                        acc_reg <= acc_next;
                    // Dropping the low N_LOG bits is the floor divide; the result always fits 32 bits.
                    if (load_means)
                        mean_reg <= acc_next[PW-1:N_LOG];
                end
            end

            assign mean_ch[gi] = mean_reg;
        end
    endgenerate

    assign accgp_next = v3_reg ? accgp_reg + $signed({{N_LOG{gp3_reg[19]}}, gp3_reg}) : accgp_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accgp_reg  <= '0;
            meangp_reg <= '0;
        end else begin
            if (clear)
                accgp_reg <= '0;
            else
                accgp_reg <= accgp_next;
            if (load_means)
                meangp_reg <= $signed({{12{accgp_next[GW-1]}}, accgp_next[GW-1:N_LOG]});
        end
    end

    assign mean_xg = mean_ch[0];
    assign mean_yg = mean_ch[1];
    assign mean_zg = mean_ch[2];
    assign mean_gp = meangp_reg;

endmodule

// File: tb/tb_ica_nonlin_acc.sv
// Directed bench for ica_nonlin_acc: frame expectations are queued when a frame's last sample
// is accepted and compared when out_valid appears.
module tb_ica_nonlin_acc;
    localparam int NL = 2;
    localparam int NS = 1 << NL;
    localparam logic [31:0] GU = 32'h7fff_ffff;
    localparam logic [15:0] GX = 16'h8000;

    logic clk = 1'b0;
    logic reset, start, in_valid, in_ready, out_valid, busy;
    logic signed [31:0] u, mean_xg, mean_yg, mean_zg, mean_gp;
    logic signed [15:0] x, y, z;

    always #5 clk = ~clk;

    ica_nonlin_acc #(.N_LOG(NL)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .u(u), .x(x), .y(y), .z(z),
        .mean_xg(mean_xg), .mean_yg(mean_yg), .mean_zg(mean_zg), .mean_gp(mean_gp),
        .out_valid(out_valid), .busy(busy)
    );

    typedef struct {
        longint xg, yg, zg, gp;
        int     due;
    } exp_t;

    exp_t    sbq[$];
    exp_t    last_exp;
    exp_t    mon_e;
    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      acc_cyc = 0;
    int      frame_no = 0;
    int      fu [NS];
    shortint fx [NS], fy [NS], fz [NS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint sat16m(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic exp_t frame_expect();
        exp_t e;
        longint uq, sq, g;
        e.xg = 0; e.yg = 0; e.zg = 0; e.gp = 0; e.due = 0;
        for (int i = 0; i < NS; i++) begin
            uq = sat16m(longint'(fu[i]) >>> 14);
            sq = (uq * uq) >>> 14;
            g  = sat16m((sq * uq) >>> 14);
            e.xg += longint'(fx[i]) * g;
            e.yg += longint'(fy[i]) * g;
            e.zg += longint'(fz[i]) * g;
            e.gp += 3 * sq;
        end
        e.xg = e.xg >>> NL;
        e.yg = e.yg >>> NL;
        e.zg = e.zg >>> NL;
        e.gp = e.gp >>> NL;
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("mean_xg", mean_xg, mon_e.xg);
                check("mean_yg", mean_yg, mon_e.yg);
                check("mean_zg", mean_zg, mon_e.zg);
                check("mean_gp", mean_gp, mon_e.gp);
                check("latency", cyc, mon_e.due);
                frame_no++;
                $display("frame %0d: xg=%0d yg=%0d zg=%0d gp=%0d cycle=%0d",
                         frame_no, mean_xg, mean_yg, mean_zg, mean_gp, cyc);
                last_exp = mon_e;
            end
        end
    end

    task automatic send(input logic [31:0] su, input logic [15:0] sx, input logic [15:0] sy,
                        input logic [15:0] sz, input logic sv, input logic sst, output logic accepted);
        u = su; x = sx; y = sy; z = sz; in_valid = sv; start = sst;
        @(negedge clk);
        accepted = sv & in_ready;
        acc_cyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic fill(input int uu, input shortint xx, input shortint yy, input shortint zz);
        for (int i = 0; i < NS; i++) begin
            fu[i] = uu; fx[i] = xx; fy[i] = yy; fz[i] = zz;
        end
    endtask

    task automatic run_frame(input bit gaps, input bit mid_start);
        int   n;
        int   tries;
        logic a;
        exp_t e;
        e = frame_expect();
        send(GU, GX, GX, GX, 1'b1, 1'b1, a);
        check("start_cycle_drop", a, 0);
        check("acc_in_ready", in_ready, 1);
        check("acc_busy", busy, 1);
        n = 0;
        tries = 0;
        while (n < NS && tries < 40) begin
            if (gaps && tries[0])
                send(GU, GX, GX, GX, 1'b0, mid_start && (tries == 1), a);
            else
                send(fu[n], fx[n], fy[n], fz[n], 1'b1, mid_start && (tries == 1), a);
            if (a) n++;
            tries++;
        end
        check("accepted", n, NS);
        e.due = acc_cyc + 4;
        sbq.push_back(e);
        check("drain_in_ready", in_ready, 0);
        check("drain_busy", busy, 1);
        for (int i = 0; i < 2; i++) begin
            send(GU, GX, GX, GX, 1'b1, 1'b0, a);
            check("drain_drop", a, 0);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("frame_completed", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; u = '0; x = '0; y = '0; z = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mean_xg", mean_xg, 0);
        check("rst_mean_yg", mean_yg, 0);
        check("rst_mean_zg", mean_zg, 0);
        check("rst_mean_gp", mean_gp, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        send(GU, GX, GX, GX, 1'b1, 1'b0, a);
        check("idle_drop", a, 0);

        fill(268435456, 16384, 16384, 16384);
        run_frame(1'b0, 1'b0);
        wait_done();

        fill(-268435456, 16384, -16384, 0);
        run_frame(1'b0, 1'b0);
        wait_done();

        fill(2147483647, 16384, -16384, 100);
        run_frame(1'b0, 1'b0);
        wait_done();

        fill(268435456, 16384, 16384, 16384);
        run_frame(1'b1, 1'b1);
        wait_done();

        for (int i = 0; i < NS; i++) begin
            fu[i] = int'($urandom());
            fx[i] = shortint'($urandom());
            fy[i] = shortint'($urandom());
            fz[i] = shortint'($urandom());
        end
        run_frame(1'b0, 1'b0);
        wait_done();

        fill(268435456, 16384, 16384, 16384);
        send(32'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, a);
        for (int i = 0; i < 2; i++) begin
            send(fu[0], fx[0], fy[0], fz[0], 1'b1, 1'b0, a);
            check("pre_reset_accept", a, 1);
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_mean_xg", mean_xg, 0);
        check("arst_mean_yg", mean_yg, 0);
        check("arst_mean_zg", mean_zg, 0);
        check("arst_mean_gp", mean_gp, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        run_frame(1'b0, 1'b0);
        wait_done();

        for (int i = 0; i < 6; i++) begin
            send($urandom(), 16'($urandom()), 16'($urandom()), 16'($urandom()), 1'b1, 1'b0, a);
            check("hold_drop", a, 0);
            check("hold_out_valid", out_valid, 0);
            check("hold_mean_xg", mean_xg, last_exp.xg);
            check("hold_mean_gp", mean_gp, last_exp.gp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ica_nonlin_acc.md
# ica_nonlin_acc

Downstream consumer of the three-tap projection PE in the ICA datapath. Each cycle it takes the PE's 32-bit projection u = w·x together with the matching 16-bit sample components x, y, z. It applies the FastICA cubic nonlinearity g(u) = u³ and its derivative g'(u) = 3u². Over a frame of 2^N_LOG samples it accumulates E{x·g(u)}, E{y·g(u)}, E{z·g(u)} and E{g'(u)}, then presents the frame means to the weight-update stage.

## Interface
- N_LOG, 8, log2 of samples per frame; frame length N = 2^N_LOG
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; opens a new frame; honoured only in IDLE
- in_valid  in  1  u, x, y, z valid this cycle
- in_ready  out  1  high only in ACC; a sample is accepted when in_valid & in_ready
- u  in  32  signed projection, Q2.28
- x, y, z  in  16 each  signed sample components, Q1.14, aligned with u
- mean_xg, mean_yg, mean_zg  out  32 each  signed frame means of x·g(u), Q2.28
- mean_gp  out  32  signed frame mean of g'(u), Q.14
- out_valid  out  1  one-cycle pulse; means valid and held until next frame's DONE
- busy  out  1  high in ACC and DRAIN

## Operation
- States: IDLE, ACC, DRAIN, DONE.
  - IDLE → ACC on start: clear all accumulators, the sample counter, and the pipeline valid bits.
  - ACC → DRAIN in the cycle the N-th sample is accepted; in_ready drops the next cycle.
  - DRAIN → DONE once the pipeline is empty.
  - DONE → IDLE unconditionally after one cycle; out_valid = 1 in DONE.
- start outside IDLE is ignored. Samples offered while in_ready = 0 are dropped and not counted.
- Pipeline, all stages registered:
  - S1: uq = sat16(u >>> 14); register x, y, z.
  - S2: sq = (uq·uq) >>> 14, 18-bit, always ≥ 0.
  - S3: g = sat16((sq·uq) >>> 14); gp = 3·sq, 20-bit.
  - S4: acc_x += x·g, acc_y += y·g, acc_z += z·g, acc_gp += gp.
- All shifts are arithmetic and floor toward −∞.
- sat16 clamps to [−32768, 32767].
- Accumulator width: 32+N_LOG bits for the product sums, 20+N_LOG bits for acc_gp. Accumulators cannot overflow within a frame.
- Means: each mean = acc >>> N_LOG, saturated to 32-bit signed, registered on entry to DONE.
- Means hold their value through IDLE and through the next frame until the next DONE.

## Timing
- Reset values: in_ready = 0, out_valid = 0, busy = 0, all means = 0, state = IDLE, accumulators and pipeline cleared.
- Pipeline throughput: 1 sample/cycle. A sample accepted in cycle t is added to the accumulators at the edge ending cycle t+3.
- DRAIN lasts exactly 3 cycles, then DONE.
- Frame latency: from the N-th accepted sample to out_valid is 4 cycles.
- Gaps in in_valid during ACC are allowed; the frame waits indefinitely.
- start and the first in_valid in the same cycle: the sample is not accepted, because in_ready is still 0.
- Reset asserted mid-frame: immediate return to reset values. Partial sums are discarded and out_valid is not pulsed.

## Test plan
- Unit frame (N_LOG=2): 4 samples, u = 268435456 (1.0), x = y = z = 16384.
  - Expect: mean_xg = mean_yg = mean_zg = 268435456, mean_gp = 49152.
  - out_valid 4 cycles after the 4th accept; in_ready low from the following cycle.
- Sign: u = −268435456, x = 16384, y = −16384, z = 0, 4 samples.
  - Expect: mean_xg = −268435456, mean_yg = 268435456, mean_zg = 0, mean_gp = 49152.
- Saturation: u = 2147483647, x = 16384.
  - Expect: uq = 32767, sq = 65532, g = 32767 (clamped), gp = 196596.
  - Expect: mean_xg = 536854528, mean_gp = 196596.
- Backpressure/gaps: in_valid toggled 1,0,1,0…; samples offered in IDLE and DRAIN.
  - Only ACC-accepted samples count; result matches the unit frame.
  - start pulsed during ACC changes nothing.
- Reset mid-frame: assert reset after 2 accepts.
  - All outputs 0 asynchronously, no out_valid.
  - A fresh frame after reset gives the unit-frame values.
- Hold: after DONE, drive random u with in_valid but no start.
  - Means unchanged, out_valid stays 0.
